serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
Sequencing controller that time-shares a single external 1-bit full adder (sum = a^b^cin, cout = majority) to add two WIDTH-bit operands bit-serially, LSB first. It accepts operands over a valid/ready input handshake, drives the full adder one bit per clock, and returns sum, carry-out and signed overflow over a valid/ready output handshake. It sits between an operand producer and a result consumer in place of a WIDTH-bit ripple adder, when area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge.
n_rst  input  1  asynchronous active-low reset.
in_valid  input  1  producer presents op_a, op_b, op_cin.
in_ready  output  1  controller can accept an operation.
op_a  input  WIDTH  operand A, unsigned or two's complement.
op_b  input  WIDTH  operand B.
op_cin  input  1  initial carry-in.
fa_a  output  1  bit to full adder input a.
fa_b  output  1  bit to full adder input b.
fa_cin  output  1  to full adder carry_in.
fa_sum  input  1  from full adder sum.
fa_cout  input  1  from full adder carry_out.
out_valid  output  1  result fields valid.
out_ready  input  1  consumer accepts result.
sum_out  output  WIDTH  result A+B+cin, mod 2^WIDTH.
cout_out  output  1  final carry-out (unsigned overflow).
ovf_out  output  1  signed overflow (carry into MSB XOR carry out of MSB).
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (n_rst low, asynchronous): state=IDLE; all internal registers cleared. in_ready=1 once n_rst is high. out_valid, busy, sum_out, cout_out, ovf_out, fa_a, fa_b, fa_cin all 0.
- Reset asserted mid-operation aborts the operation. Nothing partial is ever presented.
- Internal registers: a_sh, b_sh, s_sh (WIDTH each), carry (1), bit counter (clog2(WIDTH) bits), ovf (1).
- State machine:
  - IDLE: in_ready=1, busy=0. On in_valid at a rising edge: a_sh<=op_a, b_sh<=op_b, carry<=op_cin, counter<=0, go to RUN. Otherwise stay.
  - RUN: in_ready=0, busy=1. fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry, all combinational. Each edge:
    - s_sh <= {fa_sum, s_sh[WIDTH-1:1]}
    - a_sh and b_sh shift right by 1
    - carry<=fa_cout, counter++
    - When counter==WIDTH-1: ovf<=fa_cout^carry, go to DONE.
  - DONE: out_valid=1, busy=1, in_ready=0. sum_out=s_sh, cout_out=carry, ovf_out=ovf, all held stable. On out_ready at an edge, go to IDLE.
- fa_a, fa_b, fa_cin are forced to 0 outside RUN.
- sum_out, cout_out and ovf_out reflect the registers continuously. The consumer samples them only while out_valid=1. They are not cleared on leaving DONE.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge. Minimum issue interval is WIDTH+2 cycles (accept, WIDTH RUN cycles, 1 DONE cycle with out_ready=1).
- in_valid while not in IDLE is ignored. The producer must hold its operands until it sees in_ready=1 with in_valid at an edge.
- out_ready while not in DONE is ignored.
- out_ready held high continuously: the result is accepted on the first DONE cycle.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- WIDTH=8, op_a=0x3C, op_b=0x42, op_cin=0, out_ready=1 -> out_valid high 8 cycles after accept; sum_out=0x7E, cout_out=0, ovf_out=0; in_ready back to 1 the next cycle.
- 0xFF+0x01, cin=0 -> sum_out=0x00, cout_out=1, ovf_out=0. Also 0x7F+0x01 -> sum_out=0x80, cout_out=0, ovf_out=1. Also 0x80+0x80 -> sum_out=0x00, cout_out=1, ovf_out=1.
- 0x00+0x00, cin=1 -> sum_out=0x01. During RUN, fa_cin=1 on the first bit cycle and 0 thereafter. Check fa_a/fa_b follow operand bits LSB first.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> out_valid stays 1, outputs stable, in_ready=0, new operands not captured. Then out_ready=1 -> IDLE; a fresh operation completes correctly.
- Drop n_rst for 1 cycle at RUN bit 3 of 0x55+0xAA -> all outputs 0 immediately, busy=0. After release, in_ready=1 and the next op 0x01+0x02 gives 0x03.
- Back-to-back: in_valid and out_ready held high with a new operand pair per accept -> accepts spaced exactly 10 cycles apart. All results match a reference model over 200 random operand/cin sets.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder sequencer. It uses one external 1-bit full adder to add
//   two WIDTH-bit operands, one bit per clock, starting at the LSB. Operands
//   arrive on a valid/ready input handshake. The result comes back on a
//   valid/ready output handshake as sum, carry-out and signed overflow.
//
// Ports
//   clk, n_rst          : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (op_a, op_b, op_cin)
//   fa_a/fa_b/fa_cin    : drive the external full adder (forced to 0 outside RUN)
//   fa_sum/fa_cout      : outputs returned by the external full adder
//   out_valid/out_ready : result handshake (sum_out, cout_out, ovf_out)
//   busy                : high while an operation is in RUN or DONE
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          carry_d = op_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The sum bits enter at the MSB. After WIDTH shifts, bit 0 of the
        // operands has reached s_sh[0].
        s_sh_d  = {fa_sum, s_sh_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // On the MSB cycle, carry_q is the carry into the MSB and fa_cout
          // is the carry out of it.
          ovf_d   = fa_cout ^ carry_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode only the state register. They have no path
  // from in_valid or out_ready.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);

  assign fa_a   = (state_q == RUN) & a_sh_q[0];
  assign fa_b   = (state_q == RUN) & b_sh_q[0];
  assign fa_cin = (state_q == RUN) & carry_q;

  assign sum_out  = s_sh_q;
  assign cout_out = carry_q;
  assign ovf_out  = ovf_q;

endmodule
